// File: rtl/instruction_fetch_queue.sv
// Fetch-to-decode instruction queue: a DEPTH-entry FIFO of {pc, instruction, fault} with a valid/ready handshake on both sides and a single-cycle flush.
// Optional zero-latency empty-queue bypass is compiled in with `define FETCH_QUEUE_BYPASS_EN.
module instruction_fetch_queue #(
    parameter int DEPTH    = 4,
    parameter int PC_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push_valid,
    output logic                     push_ready,
    input  logic [PC_WIDTH-1:0]      push_pc,
    input  logic [31:0]              push_instruction,
    input  logic                     push_fault,
    output logic                     pop_valid,
    input  logic                     pop_ready,
    output logic [PC_WIDTH-1:0]      pop_pc,
    output logic [31:0]              pop_instruction,
    output logic                     pop_fault,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic [31:0]         instruction;
        logic                fault;
    } entry_t;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               full;
    logic               not_empty;
    logic               push_fire;
    logic               write_en;
    logic               read_en;
    entry_t             head_entry;
    entry_t             push_entry;

    assign full       = (count_q == CNT_W'(DEPTH));
    assign not_empty  = (count_q != '0);
    assign push_ready = ~full;
    assign push_fire  = push_valid & ~full & ~flush;
    assign read_en    = not_empty & pop_ready & ~flush;
    assign head_entry = mem_q[rd_ptr_q];
    assign push_entry = '{pc: push_pc, instruction: push_instruction, fault: push_fault};
    assign count      = count_q;

`ifdef FETCH_QUEUE_BYPASS_EN
    logic bypass_hit;

    // On an empty queue the incoming entry is presented directly; if decode takes it, it is never stored.
    assign bypass_hit = ~not_empty & push_valid & ~flush;
    assign write_en   = push_fire & ~(bypass_hit & pop_ready);
    assign pop_valid  = not_empty | bypass_hit;

    always_comb begin
        if (bypass_hit) begin
            pop_pc          = push_entry.pc;
            pop_instruction = push_entry.instruction;
            pop_fault       = push_entry.fault;
        end else begin
            pop_pc          = head_entry.pc;
            pop_instruction = head_entry.instruction;
            pop_fault       = head_entry.fault;
        end
    end
`else
    assign write_en        = push_fire;
    assign pop_valid       = not_empty;
    assign pop_pc          = head_entry.pc;
    assign pop_instruction = head_entry.instruction;
    assign pop_fault       = head_entry.fault;
`endif

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (write_en) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (read_en) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({write_en, read_en})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left out of reset; only the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (write_en) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Directed self-checking bench for instruction_fetch_queue (DEPTH=4, PC_WIDTH=32).
// Latency expectations switch on FETCH_QUEUE_BYPASS_EN to match the build.
module tb_instruction_fetch_queue;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        push_valid;
    logic        push_ready;
    logic [31:0] push_pc;
    logic [31:0] push_instruction;
    logic        push_fault;
    logic        pop_valid;
    logic        pop_ready;
    logic [31:0] pop_pc;
    logic [31:0] pop_instruction;
    logic        pop_fault;
    logic [2:0]  count;

    int checks;
    int errors;

    instruction_fetch_queue #(.DEPTH(4), .PC_WIDTH(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .flush            (flush),
        .push_valid       (push_valid),
        .push_ready       (push_ready),
        .push_pc          (push_pc),
        .push_instruction (push_instruction),
        .push_fault       (push_fault),
        .pop_valid        (pop_valid),
        .pop_ready        (pop_ready),
        .pop_pc           (pop_pc),
        .pop_instruction  (pop_instruction),
        .pop_fault        (pop_fault),
        .count            (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and land 1 time unit after the rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic pv, input logic [31:0] pc, input logic [31:0] instr,
                         input logic flt, input logic pr, input logic fl);
        push_valid       = pv;
        push_pc          = pc;
        push_instruction = instr;
        push_fault       = flt;
        pop_ready        = pr;
        flush            = fl;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        #12;
        checks++;
        if (count !== 3'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
        checks++;
        if (pop_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_pop_valid: got %b expected 0", pop_valid); end
        checks++;
        if (push_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_push_ready: got %b expected 1", push_ready); end
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_latency();
        drive(1'b1, 32'hA00, 32'hCAFE_0001, 1'b0, 1'b1, 1'b0);
        #1;
`ifdef FETCH_QUEUE_BYPASS_EN
        checks++;
        if (pop_valid !== 1'b1) begin errors++; $display("[TB] FAIL bypass_valid: got %b expected 1", pop_valid); end
        checks++;
        if (pop_pc !== 32'hA00) begin errors++; $display("[TB] FAIL bypass_pc: got %h expected 00000a00", pop_pc); end
        cycle();
        idle();
        checks++;
        if (count !== 3'd0) begin errors++; $display("[TB] FAIL bypass_count: got %0d expected 0", count); end
        checks++;
        if (pop_valid !== 1'b0) begin errors++; $display("[TB] FAIL bypass_after_valid: got %b expected 0", pop_valid); end
`else
        checks++;
        if (pop_valid !== 1'b0) begin errors++; $display("[TB] FAIL latency_same_cycle_valid: got %b expected 0", pop_valid); end
        cycle();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (count !== 3'd1) begin errors++; $display("[TB] FAIL latency_count: got %0d expected 1", count); end
        checks++;
        if (pop_valid !== 1'b1 || pop_pc !== 32'hA00) begin
            errors++; $display("[TB] FAIL latency_next_cycle: got valid=%b pc=%h expected valid=1 pc=00000a00", pop_valid, pop_pc);
        end
        cycle();
        idle();
        checks++;
        if (count !== 3'd0) begin errors++; $display("[TB] FAIL latency_drain_count: got %0d expected 0", count); end
`endif
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h100 + 32'(4 * i), 32'hA000_0000 | 32'(i), 1'b0, 1'b0, 1'b0);
            cycle();
        end
        checks++;
        if (count !== 3'd4) begin errors++; $display("[TB] FAIL fill_count: got %0d expected 4", count); end
        checks++;
        if (push_ready !== 1'b0) begin errors++; $display("[TB] FAIL fill_push_ready: got %b expected 0", push_ready); end
        drive(1'b1, 32'h200, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        cycle();
        checks++;
        if (count !== 3'd4) begin errors++; $display("[TB] FAIL fifth_push_count: got %0d expected 4", count); end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (pop_valid !== 1'b1 || pop_pc !== 32'h100 + 32'(4 * i) || pop_instruction !== (32'hA000_0000 | 32'(i))) begin
                errors++;
                $display("[TB] FAIL drain_order[%0d]: got valid=%b pc=%h instr=%h expected valid=1 pc=%h instr=%h",
                         i, pop_valid, pop_pc, pop_instruction, 32'h100 + 32'(4 * i), 32'hA000_0000 | 32'(i));
            end
            cycle();
        end
        idle();
        checks++;
        if (pop_valid !== 1'b0 || count !== 3'd0) begin
            errors++; $display("[TB] FAIL drain_empty: got valid=%b count=%0d expected valid=0 count=0", pop_valid, count);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h300 + 32'(4 * i), 32'h0, 1'b0, 1'b0, 1'b0);
            cycle();
        end
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 32'h308 + 32'(4 * k), 32'h0, 1'b0, 1'b1, 1'b0);
            #1;
            checks++;
            if (pop_valid !== 1'b1 || pop_pc !== 32'h300 + 32'(4 * k)) begin
                errors++; $display("[TB] FAIL wrap_pc[%0d]: got valid=%b pc=%h expected valid=1 pc=%h", k, pop_valid, pop_pc, 32'h300 + 32'(4 * k));
            end
            cycle();
            checks++;
            if (count !== 3'd2) begin errors++; $display("[TB] FAIL wrap_count[%0d]: got %0d expected 2", k, count); end
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (pop_pc !== 32'h328 + 32'(4 * i)) begin
                errors++; $display("[TB] FAIL wrap_tail[%0d]: got %h expected %h", i, pop_pc, 32'h328 + 32'(4 * i));
            end
            cycle();
        end
        idle();
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h400 + 32'(4 * i), 32'h0, 1'b0, 1'b0, 1'b0);
            cycle();
        end
        drive(1'b1, 32'h500, 32'h0, 1'b0, 1'b1, 1'b0);
        cycle();
        checks++;
        if (count !== 3'd3) begin errors++; $display("[TB] FAIL full_pop_count: got %0d expected 3", count); end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (pop_valid !== 1'b1 || pop_pc !== 32'h404 + 32'(4 * i)) begin
                errors++; $display("[TB] FAIL full_pop_order[%0d]: got valid=%b pc=%h expected valid=1 pc=%h", i, pop_valid, pop_pc, 32'h404 + 32'(4 * i));
            end
            cycle();
        end
        idle();
        checks++;
        if (pop_valid !== 1'b0) begin errors++; $display("[TB] FAIL full_pop_refused_entry: got valid=%b pc=%h expected valid=0", pop_valid, pop_pc); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h600 + 32'(4 * i), 32'h0, 1'b0, 1'b0, 1'b0);
            cycle();
        end
        drive(1'b1, 32'h700, 32'h0, 1'b0, 1'b1, 1'b1);
        cycle();
        checks++;
        if (count !== 3'd0 || pop_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL flush_clear: got count=%0d valid=%b expected count=0 valid=0", count, pop_valid);
        end
        drive(1'b1, 32'h800, 32'h0, 1'b0, 1'b0, 1'b0);
        cycle();
        checks++;
        if (count !== 3'd1 || pop_pc !== 32'h800) begin
            errors++; $display("[TB] FAIL flush_next_push: got count=%0d pc=%h expected count=1 pc=00000800", count, pop_pc);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h804 + 32'(4 * i), 32'h0, 1'b0, 1'b0, 1'b0);
            cycle();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        #1;
        checks++;
        if (push_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_push_ready_full: got %b expected 0", push_ready); end
        cycle();
        idle();
        checks++;
        if (count !== 3'd0 || push_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL flush_from_full: got count=%0d ready=%b expected count=0 ready=1", count, push_ready);
        end
    endtask

    task automatic test_fault();
        drive(1'b1, 32'h900, 32'h0000_0013, 1'b1, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 32'h904, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
        cycle();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (pop_instruction !== 32'h0000_0013 || pop_fault !== 1'b1 || pop_pc !== 32'h900) begin
            errors++; $display("[TB] FAIL fault_entry: got pc=%h instr=%h fault=%b expected pc=00000900 instr=00000013 fault=1", pop_pc, pop_instruction, pop_fault);
        end
        cycle();
        checks++;
        if (pop_instruction !== 32'h1234_5678 || pop_fault !== 1'b0) begin
            errors++; $display("[TB] FAIL clean_entry: got instr=%h fault=%b expected instr=12345678 fault=0", pop_instruction, pop_fault);
        end
        cycle();
        idle();
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'hB00 + 32'(4 * i), 32'h0, 1'b0, 1'b0, 1'b0);
            cycle();
        end
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (count !== 3'd0 || pop_valid !== 1'b0 || push_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL async_reset: got count=%0d valid=%b ready=%b expected count=0 valid=0 ready=1", count, pop_valid, push_ready);
        end
        #2;
        rst_n = 1'b1;
        cycle();
        drive(1'b1, 32'hC00, 32'h0, 1'b0, 1'b0, 1'b0);
        cycle();
        idle();
        checks++;
        if (count !== 3'd1 || pop_pc !== 32'hC00) begin
            errors++; $display("[TB] FAIL reset_first_pop: got count=%0d pc=%h expected count=1 pc=00000c00", count, pop_pc);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle();
        test_reset();
        test_latency();
        test_fill_drain();
        test_wrap();
        test_full_pop();
        test_flush();
        test_fault();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
